// File: rtl/dll_phase_update_pkg.sv
// dll_phase_update_pkg: shared DLL widths, reset increment, clamp bounds and FSM encoding
package dll_phase_update_pkg;
  localparam int CH_W = 2;
  localparam int DPHI_W = 16;
  localparam int INC_W = 24;
  localparam logic [INC_W-1:0] INC_NOM = 24'h100000;
  localparam int INC_MIN = 1;
  localparam logic [INC_W-1:0] INC_MAX = '1;
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, APPLY = 2'd2} state_t;
endpackage

// File: rtl/dll_result_fifo.sv
// dll_result_fifo: pending-result queue with same-cycle bypass when empty
module dll_result_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             global_reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             accepted,
  output logic             avail,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [AW:0] count;
  logic wr, rd;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign avail = !empty || push;
  assign accepted = push && (!full || pop);
  assign wr = accepted && !(empty && pop);
  assign rd = pop && !empty;
  assign dout = empty ? din : mem[rptr];
  always_ff @(posedge clk or posedge global_reset)
    if (global_reset) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= din;
endmodule

// File: rtl/dll_phase_update.sv
// dll_phase_update: per-channel code-rate increment store with queued, clamped DLL corrections
module dll_phase_update
  import dll_phase_update_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int CHANNEL_ID_WIDTH = CH_W,
  parameter int DPHI_WIDTH = DPHI_W,
  parameter int INC_WIDTH = INC_W,
  parameter logic [INC_WIDTH-1:0] INC_NOMINAL = INC_NOM,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        global_reset,
  input  logic                        result_ready,
  input  logic [CHANNEL_ID_WIDTH-1:0] result_tag,
  input  logic [DPHI_WIDTH-1:0]       delta_phase_increment,
  input  logic                        init_valid,
  input  logic [CHANNEL_ID_WIDTH-1:0] init_tag,
  input  logic [INC_WIDTH-1:0]        init_value,
  input  logic [CHANNEL_ID_WIDTH-1:0] rd_tag,
  output logic [INC_WIDTH-1:0]        rd_inc,
  output logic                        upd_valid,
  output logic [CHANNEL_ID_WIDTH-1:0] upd_tag,
  output logic [INC_WIDTH-1:0]        upd_inc,
  output logic                        sat_event,
  output logic                        overflow
);
  localparam int SW = INC_WIDTH + 2;
  localparam int FW = CHANNEL_ID_WIDTH + DPHI_WIDTH;
  state_t state, nxt;
  logic [CHANNEL_ID_WIDTH-1:0] tag_q;
  logic [DPHI_WIDTH-1:0] dphi_q;
  logic [INC_WIDTH-1:0] old_q, clamped;
  logic [INC_WIDTH-1:0] arr [NUM_CHANNELS];
  logic [INC_WIDTH-1:0] arr_nxt [NUM_CHANNELS];
  logic [FW-1:0] dout;
  logic [SW-1:0] sum;
  logic push, pop, accepted, avail, full, empty;
  logic cancel_q, hit, apply, lo, hi;
  assign push = result_ready && int'(result_tag) < NUM_CHANNELS;
  dll_result_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .global_reset(global_reset),
    .push(push),
    .pop(pop),
    .din({result_tag, delta_phase_increment}),
    .dout(dout),
    .accepted(accepted),
    .avail(avail),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or posedge global_reset)
    if (global_reset) state <= IDLE;
    else state <= nxt;
  always_comb nxt = state == FETCH ? APPLY : pop ? FETCH : IDLE;
  // init to the in-flight channel during FETCH or APPLY voids that update
  always_comb begin
    hit = init_valid && init_tag == tag_q;
    pop = state != FETCH && avail;
    apply = state == APPLY && !cancel_q && !hit;
  end
  // two guard bits: top bit flags a negative sum, next one a sum past the maximum
  always_comb begin
    sum = {2'b00, old_q} + {{(SW-DPHI_WIDTH){dphi_q[DPHI_WIDTH-1]}}, dphi_q};
    lo = sum[SW-1] || sum == '0;
    hi = !sum[SW-1] && sum[SW-2];
    clamped = lo ? INC_WIDTH'(INC_MIN) : hi ? '1 : sum[INC_WIDTH-1:0];
  end
  always_comb
    for (int i = 0; i < NUM_CHANNELS; i++)
      arr_nxt[i] = (init_valid && int'(init_tag) == i) ? init_value :
                   (apply && int'(tag_q) == i) ? clamped : arr[i];
  always_ff @(posedge clk or posedge global_reset)
    if (global_reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) arr[i] <= INC_NOMINAL;
      tag_q <= '0;
      dphi_q <= '0;
      old_q <= '0;
      cancel_q <= 1'b0;
      rd_inc <= '0;
      upd_valid <= 1'b0;
      upd_tag <= '0;
      upd_inc <= '0;
      sat_event <= 1'b0;
      overflow <= 1'b0;
    end else begin
      arr <= arr_nxt;
      if (pop) {tag_q, dphi_q} <= dout;
      if (state == FETCH) old_q <= arr[tag_q];
      cancel_q <= state == FETCH && hit;
      rd_inc <= int'(rd_tag) < NUM_CHANNELS ? arr_nxt[rd_tag] : '0;
      upd_valid <= apply;
      sat_event <= apply && (lo || hi);
      if (apply) begin
        upd_tag <= tag_q;
        upd_inc <= clamped;
      end
      overflow <= overflow || (push && !accepted);
    end
endmodule

// File: tb/tb_dll_phase_update.sv
// tb_dll_phase_update: scoreboard bench with a queue-level reference model of the DLL update engine
module tb_dll_phase_update;
  logic clk = 1'b0;
  logic global_reset = 1'b1;
  logic result_ready = 1'b0;
  logic [1:0] result_tag = '0;
  logic [15:0] delta_phase_increment = '0;
  logic init_valid = 1'b0;
  logic [1:0] init_tag = '0;
  logic [23:0] init_value = '0;
  logic [1:0] rd_tag = '0;
  logic [23:0] rd_inc;
  logic upd_valid;
  logic [1:0] upd_tag;
  logic [23:0] upd_inc;
  logic sat_event;
  logic overflow;
  always #5 clk = ~clk;
  dll_phase_update dut (
    .clk(clk),
    .global_reset(global_reset),
    .result_ready(result_ready),
    .result_tag(result_tag),
    .delta_phase_increment(delta_phase_increment),
    .init_valid(init_valid),
    .init_tag(init_tag),
    .init_value(init_value),
    .rd_tag(rd_tag),
    .rd_inc(rd_inc),
    .upd_valid(upd_valid),
    .upd_tag(upd_tag),
    .upd_inc(upd_inc),
    .sat_event(sat_event),
    .overflow(overflow)
  );
  typedef struct {logic [1:0] tag; logic [15:0] dphi;} res_t;
  typedef struct {logic [1:0] tag; logic [23:0] inc; logic sat; int due;} upd_t;
  res_t mq[$];
  upd_t expq[$];
  logic [23:0] marr [4];
  logic [23:0] rd_exp = '0;
  bit busy, cancelled, movf;
  res_t cur;
  int s, cyc;
  int checks = 0;
  int errors = 0;
  task automatic chk(input bit ok, input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask
  // reference: a 4-deep queue feeding an engine that takes a result, then commits it two cycles later
  always @(posedge clk) begin
    cyc++;
    if (global_reset) begin
      mq.delete();
      expq.delete();
      busy = 0;
      cancelled = 0;
      movf = 0;
      rd_exp = '0;
      foreach (marr[i]) marr[i] = 24'h100000;
    end else begin
      bit popping, accept, got;
      if (busy && init_valid && init_tag == cur.tag && cyc - s >= 1) cancelled = 1;
      if (busy && cyc - s == 2) begin
        busy = 0;
        if (!cancelled) begin
          longint v;
          upd_t u;
          v = longint'(marr[cur.tag]) + longint'($signed(cur.dphi));
          u.sat = v < 1 || v > 64'hFFFFFF;
          v = v < 1 ? 1 : v > 64'hFFFFFF ? 64'hFFFFFF : v;
          u.inc = 24'(v);
          u.tag = cur.tag;
          u.due = cyc;
          marr[cur.tag] = u.inc;
          expq.push_back(u);
        end
      end
      if (init_valid) marr[init_tag] = init_value;
      popping = !busy && (mq.size() > 0 || result_ready);
      accept = result_ready && (mq.size() < 4 || popping);
      got = 0;
      if (popping && mq.size() > 0) begin
        cur = mq.pop_front();
        got = 1;
      end
      if (accept) mq.push_back('{result_tag, delta_phase_increment});
      if (popping && !got) cur = mq.pop_front();
      if (popping) begin
        busy = 1;
        s = cyc;
        cancelled = 0;
      end
      if (result_ready && !accept) movf = 1;
      rd_exp = marr[rd_tag];
    end
  end
  always @(negedge clk) begin
    if (global_reset)
      chk(rd_inc == 0 && !upd_valid && upd_tag == 0 && upd_inc == 0 && !sat_event && !overflow,
          "reset_state", {rd_inc, upd_inc, upd_tag, upd_valid, sat_event, overflow}, 0);
    else begin
      chk(rd_inc == rd_exp, "rd_inc", rd_inc, rd_exp);
      chk(overflow == movf, "overflow", overflow, movf);
      if (upd_valid) begin
        chk(expq.size() > 0, "upd_spurious", {upd_tag, upd_inc}, 0);
        if (expq.size() > 0) begin
          upd_t u;
          u = expq.pop_front();
          chk({upd_tag, upd_inc, sat_event} == {u.tag, u.inc, u.sat}, "upd",
              {upd_tag, upd_inc, sat_event}, {u.tag, u.inc, u.sat});
        end
      end else if (expq.size() > 0 && expq[0].due <= cyc) begin
        chk(upd_valid == 1'b1, "upd_missing", {expq[0].tag, expq[0].inc}, 1);
        void'(expq.pop_front());
      end
    end
  end
  task automatic drive(input bit rr, input logic [1:0] rt, input logic [15:0] dp, input bit iv,
                       input logic [1:0] it, input logic [23:0] ival, input logic [1:0] rdt);
    @(posedge clk);
    #2;
    result_ready = rr;
    result_tag = rt;
    delta_phase_increment = dp;
    init_valid = iv;
    init_tag = it;
    init_value = ival;
    rd_tag = rdt;
  endtask
  task automatic idle(input int n, input logic [1:0] rdt);
    repeat (n) drive(0, 0, 0, 0, 0, 0, rdt);
  endtask
  initial begin
    logic [1:0] chans [6];
    chans = '{0, 1, 2, 3, 0, 1};
    repeat (3) @(posedge clk);
    #2 global_reset = 0;
    idle(3, 2);
    drive(1, 1, 16'h0040, 0, 0, 0, 1);
    idle(5, 1);
    drive(0, 0, 0, 1, 0, 24'h000010, 0);
    drive(1, 0, 16'hFFE0, 0, 0, 0, 0);
    idle(5, 0);
    drive(0, 0, 0, 1, 0, 24'hFFFFF0, 0);
    drive(1, 0, 16'h0100, 0, 0, 0, 0);
    idle(5, 0);
    for (int i = 0; i < 6; i++) drive(1, chans[i], 16'h0008 << i, 0, 0, 0, 2'(i));
    idle(16, 3);
    for (int i = 0; i < 12; i++) drive(1, 2'(i), 16'($urandom_range(0, 511)) - 16'd256, 0, 0, 0, 2'(i));
    idle(24, 0);
    drive(1, 2, 16'h0010, 0, 0, 0, 2);
    idle(1, 2);
    drive(0, 0, 0, 1, 2, 24'h123456, 2);
    idle(5, 2);
    for (int i = 0; i < 7; i++) drive(1, 2'(i), 16'h0004, 0, 0, 0, 1);
    idle(1, 1);
    #1 global_reset = 1;
    repeat (2) @(posedge clk);
    #2 global_reset = 0;
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 2'(i));
    idle(6, 3);
    for (int i = 0; i < 400; i++) begin
      logic [15:0] dp;
      logic [23:0] iv;
      dp = $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'($urandom_range(0, 511)) - 16'd256;
      iv = $urandom_range(0, 2) == 0 ? 24'h000020 : $urandom_range(0, 1) == 0 ? 24'hFFFF80 : 24'($urandom);
      drive($urandom_range(0, 2) == 0, 2'($urandom), dp, $urandom_range(0, 9) == 0, 2'($urandom), iv, 2'($urandom));
    end
    idle(20, 0);
    chk(expq.size() == 0, "pending_updates", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
